// File: rtl/i_serdes_deserializer_if.sv
// Receive-side deserializer bus: serial input, control and parallel word output.
// master drives the serial side, slave is the deserializer itself.
interface i_serdes_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             D;
  logic             EN;
  logic             PLL_LOCK;
  logic             CHANNEL_BOND_SYNC_IN;
  logic             BITSLIP;
  logic [WIDTH-1:0] Q;
  logic             DATA_VALID;
  logic             CHANNEL_BOND_SYNC_OUT;

  modport master (
    output D,
    output EN,
    output PLL_LOCK,
    output CHANNEL_BOND_SYNC_IN,
    output BITSLIP,
    input  Q,
    input  DATA_VALID,
    input  CHANNEL_BOND_SYNC_OUT
  );

  modport slave (
    input  D,
    input  EN,
    input  PLL_LOCK,
    input  CHANNEL_BOND_SYNC_IN,
    input  BITSLIP,
    output Q,
    output DATA_VALID,
    output CHANNEL_BOND_SYNC_OUT
  );
endinterface

// File: rtl/i_serdes_deserializer.sv
// SDR deserializer: frames serial bits into WIDTH-bit words (first bit in MSB),
// with lock gating, channel-bond start and bit-slip alignment.
module i_serdes_deserializer #(
  parameter int WIDTH = 4
) (
  input logic                  CLK_IN,
  input logic                  RST,
  i_serdes_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SYNC,
    RUN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    lk_cnt_q;
  logic             lk_act_q;
  logic             pend_q;
  logic             bs_prev_q;
  logic             dv_q;
  logic             cbo_q;

  logic             start;
  logic             active;
  logic             shift;
  logic             rise;
  logic             slip_now;
  logic             emit;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (bus.PLL_LOCK) state_d = SYNC;
      end
      SYNC: begin
        if (bus.CHANNEL_BOND_SYNC_IN) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
    if (!bus.PLL_LOCK) begin
      state_d = WAIT_LOCK;
      start   = 1'b0;
    end
  end

  // A slip applies on the first enabled shift at or after the edge.
  always_comb begin
    active   = (state_q == RUN) && bus.PLL_LOCK;
    shift    = active && bus.EN;
    rise     = active && bus.BITSLIP && !bs_prev_q
               && !pend_q && !lk_act_q;
    slip_now = shift && (rise || pend_q);
    emit     = shift && !slip_now && (cnt_q == LAST);
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state_q <= WAIT_LOCK;
      sr_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      lk_cnt_q  <= '0;
      lk_act_q  <= 1'b0;
      pend_q    <= 1'b0;
      bs_prev_q <= 1'b0;
      dv_q    <= 1'b0;
      cbo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bs_prev_q <= bus.BITSLIP;
      dv_q      <= emit;
      cbo_q     <= start;
      if (shift) sr_q <= {sr_q[WIDTH-2:0], bus.D};
      if (emit)  q_q  <= {sr_q[WIDTH-2:0], bus.D};
      if (!active) begin
        cnt_q    <= '0;
        pend_q   <= 1'b0;
        lk_act_q <= 1'b0;
        lk_cnt_q <= '0;
      end else begin
        if (shift && !slip_now) begin
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
        pend_q <= (pend_q || rise) && !shift;
        // Lockout spans WIDTH enabled shifts after the slip shift.
        if (slip_now) begin
          lk_act_q <= 1'b1;
          lk_cnt_q <= '0;
        end else if (shift && lk_act_q) begin
          if (lk_cnt_q == LAST) lk_act_q <= 1'b0;
          else lk_cnt_q <= lk_cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.Q                     = q_q;
  assign bus.DATA_VALID            = dv_q;
  assign bus.CHANNEL_BOND_SYNC_OUT = cbo_q;
endmodule
